bgr_startup_ctrl: RTL and testbench
===================================

# bgr_startup_ctrl

Digital start-up and trim sequencer for one or more sky130 bandgap reference channels. It drives each channel's `porst` start-up kick device and waits for the core to settle. It then checks a per-channel "vbg good" comparator, retrying the kick a bounded number of times, and ramps each channel's resistor-ladder trim code one LSB at a time to its target. It sits between the chip-level power-management logic and the analog `bgr_top` instances, and generalises the single fixed start-up transistor to N channels with trim and supervision.

## Interface
- `NCH`, 2: number of bandgap channels.
- `TRIM_W`, 5: trim code width per channel.
- `PULSE_CYC`, 16: `porst` kick pulse length in cycles (>=1).
- `SETTLE_CYC`, 1024: settle wait after the kick, in cycles (>=1).
- `RAMP_CYC`, 8: cycles per trim LSB step (>=1).
- `MAX_RETRY`, 3: kick retries before declaring failure.
- `DROP_CYC`, 4: consecutive low-`ok` cycles in DONE that trigger a restart.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  sequencer enable, level sensitive.
- `ch_en`  in  NCH  channel enable mask, captured on IDLE exit into `en_q`.
- `trim_target`  in  NCH*TRIM_W  target code; channel i is `[i*TRIM_W +: TRIM_W]`.
- `ok_async`  in  NCH  asynchronous vbg-good comparator outputs.
- `porst`  out  NCH  start-up kick per channel, active high.
- `trim`  out  NCH*TRIM_W  applied trim codes, same packing as `trim_target`.
- `ready`  out  1  all enabled channels up and trimmed.
- `fail`  out  1  retry budget exhausted.
- `busy`  out  1  state is not IDLE, DONE or FAIL.
- `retries`  out  clog2(MAX_RETRY+1)  retries used in the current attempt.

## Operation
- `ok_async` passes through a 2-flop synchroniser to give `ok_s`. All decisions use `ok_s`.
- All outputs are registered. Reset values: `porst`=0, `trim`=0, `ready`=0, `fail`=0, `busy`=0, `retries`=0, `en_q`=0, state IDLE.
- `en`=0 in any state sends the block to IDLE on the next edge. This has priority over every other transition. `porst`, `ready` and `fail` clear, `retries` clears, and `trim` holds its value.
- The state machine:
  - IDLE: if `en`=1 and `ch_en`!=0, capture `en_q`<=`ch_en` and go to KICK. If `ch_en`==0, stay in IDLE.
  - KICK: `porst`=`en_q` for exactly PULSE_CYC cycles, then SETTLE. `porst` is 0 in every other state.
  - SETTLE: wait SETTLE_CYC cycles, then CHECK.
  - CHECK: single cycle.
    - If `(ok_s & en_q)==en_q`, go to RAMP.
    - Otherwise, if `retries`==MAX_RETRY, go to FAIL.
    - Otherwise increment `retries` and go to KICK.
  - RAMP: each time a RAMP_CYC-cycle tick expires, every enabled channel whose `trim`!=target steps by +1 or -1 toward its target. Disabled channels hold their value. The target is sampled live. When all enabled channels match, go to DONE. If they already match on entry, DONE follows on the next cycle.
  - DONE: `ready`=1.
    - If any enabled channel's target differs from its `trim`, go to RAMP, with `ready`=0 from that cycle.
    - If any enabled `ok_s` is low for DROP_CYC consecutive cycles, clear `retries` and go to KICK. The trim value is held.
    - If both conditions occur in the same cycle, the drop restart wins.
  - FAIL: `fail`=1, held until `en`=0.
- Trim steps never wrap: a code only moves toward the target, so 0 and 2^TRIM_W-1 are never overstepped.
- Changes to `ch_en` after capture are ignored until the block re-enters IDLE.

## Timing
- `ok_async` to `ok_s` latency: 2 cycles.
- The IDLE exit edge is the first edge where `en`=1 is sampled. `porst` goes high on that edge and stays high for PULSE_CYC cycles.
- From the first `porst` cycle, CHECK occurs PULSE_CYC+SETTLE_CYC cycles later.
- `ready` latency, assuming a first-pass CHECK: 1 + PULSE_CYC + SETTLE_CYC + 1 + RAMP_CYC × max|target−trim| cycles after `en` rises, plus 1 cycle into DONE.
- Each retry adds PULSE_CYC+SETTLE_CYC+1 cycles.
- The RAMP tick counter restarts on RAMP entry, so the first step occurs RAMP_CYC cycles after entry.
- The DONE drop counter resets whenever all enabled `ok_s` are high.
- Reset assertion mid-sequence forces reset values immediately, asynchronously. Reset deassertion is synchronised by the system.

## Test plan
- Nominal: defaults, `ch_en`=2'b11, `ok_async`=11 held, targets 5 and 3. Required: `porst`=11 for 16 cycles, then CHECK passes. `trim` ch0 steps 0→5 every 8 cycles, ch1 steps 0→3. `ready`=1 at cycle 1+16+1024+1+40+1.
- Retry then fail: `ok_async`=00 throughout. Required: 4 kick pulses, `retries` goes 0,1,2,3, then `fail`=1 and `busy`=0. Drop `en`: IDLE next cycle, `fail`=0.
- Late good: `ok_async`=11 raised during the second SETTLE. Required: exactly one retry and `retries`=1 at `ready`.
- Channel mask: `ch_en`=2'b01 with ch1 `ok`=0. Required: `porst`=01, CHECK passes, and ch1 `trim` stays 0.
- Supervision: in DONE, ch0 `ok` low for 3 cycles gives no action. Low for 4 cycles gives KICK, `ready`=0 and `retries`=0, with `trim` held. A simultaneous target change still results in KICK.
- Retrim and abort: in DONE, change the ch0 target 5→2. Required: RAMP, down-steps 4,3,2, then `ready`. Then `en`=0 mid-RAMP: IDLE next cycle with `trim` held.

Source files
------------

// File: rtl/bgr_startup_ctrl_if.sv
// Control/status bundle between power-management logic and the bandgap
// start-up sequencer.
//   master : drives en, ch_en, trim_target, ok_async; observes status
//   slave  : the sequencer; drives porst, trim, ready, fail, busy, retries
// ok_async comes from the analog comparators and is carried here so the
// sequencer sees one bundle per bandgap group.
interface bgr_startup_ctrl_if #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned TRIM_W    = 5,
  parameter int unsigned MAX_RETRY = 3
);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic                     en;
  logic [NCH-1:0]           ch_en;
  logic [NCH*TRIM_W-1:0]    trim_target;
  logic [NCH-1:0]           ok_async;
  logic [NCH-1:0]           porst;
  logic [NCH*TRIM_W-1:0]    trim;
  logic                     ready;
  logic                     fail;
  logic                     busy;
  logic [RETRY_W-1:0]       retries;

  modport master (
    output en, ch_en, trim_target, ok_async,
    input  porst, trim, ready, fail, busy, retries
  );

  modport slave (
    input  en, ch_en, trim_target, ok_async,
    output porst, trim, ready, fail, busy, retries
  );
endinterface

// File: rtl/bgr_startup_ctrl.sv
// Start-up and trim sequencer for NCH bandgap reference channels.
// Kicks each enabled channel's porst device, waits for settling, checks the
// synchronised vbg-good comparators (with a bounded number of retries), then
// ramps each channel's trim code one LSB per RAMP_CYC cycles to its target.
// In DONE it supervises ok and re-kicks after DROP_CYC consecutive low cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bgr_startup_ctrl_if
//                in : en, ch_en, trim_target, ok_async
//                out: porst, trim, ready, fail, busy, retries (all registered)
module bgr_startup_ctrl #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned TRIM_W     = 5,
  parameter int unsigned PULSE_CYC  = 16,
  parameter int unsigned SETTLE_CYC = 1024,
  parameter int unsigned RAMP_CYC   = 8,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned DROP_CYC   = 4
) (
  input logic               clk,
  input logic               rst_n,
  bgr_startup_ctrl_if.slave bus
);

  localparam int unsigned TW      = NCH * TRIM_W;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // One shared down/up counter serves the pulse, settle, ramp tick and drop
  // windows; they never overlap in time.
  localparam int unsigned MAX_A   = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int unsigned MAX_B   = (RAMP_CYC > DROP_CYC) ? RAMP_CYC : DROP_CYC;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]   PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   RAMP_LD   = CNT_W'(RAMP_CYC - 1);
  localparam logic [CNT_W-1:0]   DROP_LAST = CNT_W'(DROP_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_SETTLE,
    S_CHECK,
    S_RAMP,
    S_DONE,
    S_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic [NCH-1:0]     en_q, en_d;
  logic [NCH-1:0]     porst_q, porst_d;
  logic [TW-1:0]      trim_q, trim_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               busy_q, busy_d;
  logic [NCH-1:0]     ok_meta_q, ok_s_q;

  logic [TW-1:0]      trim_step_c;
  logic               match_c;
  logic               ok_all_c;
  logic               ok_drop_c;

  // Good means every enabled channel's synchronised comparator is high.
  assign ok_all_c  = ((ok_s_q & en_q) == en_q);
  assign ok_drop_c = |(~ok_s_q & en_q);

  // Per-channel one-LSB step toward the live target; never wraps since a
  // code only moves when it is strictly below or above its target.
  always_comb begin
    trim_step_c = trim_q;
    match_c     = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (en_q[i]) begin
        if (trim_q[i*TRIM_W +: TRIM_W] < bus.trim_target[i*TRIM_W +: TRIM_W]) begin
          trim_step_c[i*TRIM_W +: TRIM_W] = trim_q[i*TRIM_W +: TRIM_W] + TRIM_W'(1);
          match_c = 1'b0;
        end else if (trim_q[i*TRIM_W +: TRIM_W] > bus.trim_target[i*TRIM_W +: TRIM_W]) begin
          trim_step_c[i*TRIM_W +: TRIM_W] = trim_q[i*TRIM_W +: TRIM_W] - TRIM_W'(1);
          match_c = 1'b0;
        end
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    en_d      = en_q;
    porst_d   = '0;
    trim_d    = trim_q;
    ready_d   = 1'b0;
    fail_d    = 1'b0;

    if (!bus.en) begin
      // Disable beats everything; trim codes are deliberately kept.
      state_d   = S_IDLE;
      retries_d = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.ch_en != '0) begin
            en_d      = bus.ch_en;
            porst_d   = bus.ch_en;
            retries_d = '0;
            cnt_d     = PULSE_LD;
            state_d   = S_KICK;
          end
        end

        S_KICK: begin
          if (cnt_q == '0) begin
            cnt_d   = SETTLE_LD;
            state_d = S_SETTLE;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            porst_d = en_q;
          end
        end

        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_CHECK: begin
          if (ok_all_c) begin
            cnt_d   = RAMP_LD;
            state_d = S_RAMP;
          end else if (retries_q == RETRY_LIM) begin
            fail_d  = 1'b1;
            state_d = S_FAIL;
          end else begin
            retries_d = retries_q + RETRY_W'(1);
            porst_d   = en_q;
            cnt_d     = PULSE_LD;
            state_d   = S_KICK;
          end
        end

        S_RAMP: begin
          // Completion is judged on the applied code, so DONE follows the
          // final step by one cycle.
          if (match_c) begin
            ready_d = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end else if (cnt_q == '0) begin
            trim_d = trim_step_c;
            cnt_d  = RAMP_LD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_DONE: begin
          // cnt_q counts consecutive cycles with an enabled ok low.
          ready_d = 1'b1;
          if (ok_drop_c && (cnt_q == DROP_LAST)) begin
            ready_d   = 1'b0;
            retries_d = '0;
            porst_d   = en_q;
            cnt_d     = PULSE_LD;
            state_d   = S_KICK;
          end else if (!match_c) begin
            ready_d = 1'b0;
            cnt_d   = RAMP_LD;
            state_d = S_RAMP;
          end else if (ok_drop_c) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
          end
        end

        S_FAIL: begin
          fail_d = 1'b1;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_FAIL);
  end

  // State, output registers and ok synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_meta_q <= '0;
      ok_s_q    <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retries_q <= '0;
      en_q      <= '0;
      porst_q   <= '0;
      trim_q    <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ok_meta_q <= bus.ok_async;
      ok_s_q    <= ok_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      en_q      <= en_d;
      porst_q   <= porst_d;
      trim_q    <= trim_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.porst   = porst_q;
  assign bus.trim    = trim_q;
  assign bus.ready   = ready_q;
  assign bus.fail    = fail_q;
  assign bus.busy    = busy_q;
  assign bus.retries = retries_q;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Self-checking bench for bgr_startup_ctrl: directed scenarios plus random
// targets/masks, checked against arithmetic timing and trim-sequence models.
module tb_bgr_startup_ctrl;

  localparam int unsigned NCH       = 2;
  localparam int unsigned TRIM_W    = 5;
  localparam int unsigned P         = 16;
  localparam int unsigned S         = 1024;
  localparam int unsigned R         = 8;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned DROP      = 4;
  localparam int          TMAX      = (1 << TRIM_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bgr_startup_ctrl_if #(.NCH(NCH), .TRIM_W(TRIM_W), .MAX_RETRY(MAX_RETRY)) bus ();

  bgr_startup_ctrl #(
    .NCH(NCH), .TRIM_W(TRIM_W), .PULSE_CYC(P), .SETTLE_CYC(S),
    .RAMP_CYC(R), .MAX_RETRY(MAX_RETRY), .DROP_CYC(DROP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int             tgt    [NCH];
  int             trim_m [NCH];
  logic [NCH-1:0] mask_m;

  // Observation statistics since the last clear_stats()
  int             edges;
  int             porst_cyc;
  int             kick_n;
  int             kick_ret [$];
  int             chg [NCH][$];
  logic [NCH-1:0] prev_porst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int trim_of(input int i);
    logic [NCH*TRIM_W-1:0] t;
    t = bus.trim;
    return int'(t[i*TRIM_W +: TRIM_W]);
  endfunction

  function automatic int max_dist();
    int m;
    m = 0;
    for (int i = 0; i < NCH; i++) begin
      int d;
      d = tgt[i] - trim_m[i];
      if (d < 0) d = -d;
      if (mask_m[i] && d > m) m = d;
    end
    return m;
  endfunction

  // Edges from the en-rise edge to ready, for a given ramp distance and retry count.
  function automatic int ready_lat(input int d, input int nret);
    return 1 + P + S + 1 + R * d + 1 + nret * (P + S + 1);
  endfunction

  task automatic drive_tgt();
    logic [NCH*TRIM_W-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*TRIM_W +: TRIM_W] = TRIM_W'(tgt[i]);
    bus.trim_target = v;
  endtask

  task automatic clear_stats();
    edges      = 0;
    porst_cyc  = 0;
    kick_n     = 0;
    prev_porst = '0;
    kick_ret.delete();
    for (int i = 0; i < NCH; i++) chg[i].delete();
  endtask

  // One clock; observe on the falling edge.
  task automatic tick();
    logic [NCH*TRIM_W-1:0] prev_trim;
    logic [NCH*TRIM_W-1:0] now_trim;
    prev_trim = bus.trim;
    @(posedge clk);
    @(negedge clk);
    edges++;
    now_trim = bus.trim;
    if (bus.porst != '0) begin
      porst_cyc++;
      if (prev_porst == '0) begin
        kick_n++;
        kick_ret.push_back(int'(bus.retries));
      end
    end
    prev_porst = bus.porst;
    for (int i = 0; i < NCH; i++)
      if (now_trim[i*TRIM_W +: TRIM_W] != prev_trim[i*TRIM_W +: TRIM_W])
        chg[i].push_back(int'(now_trim[i*TRIM_W +: TRIM_W]));
  endtask

  task automatic start_run(input logic [NCH-1:0] mask, input logic [NCH-1:0] okv);
    mask_m       = mask;
    bus.ch_en    = mask;
    bus.ok_async = okv;
    drive_tgt();
    clear_stats();
    bus.en = 1'b1;
  endtask

  task automatic stop(input string tag);
    bus.en = 1'b0;
    tick();
    chk({tag, "_busy"},    bus.busy,    0);
    chk({tag, "_ready"},   bus.ready,   0);
    chk({tag, "_fail"},    bus.fail,    0);
    chk({tag, "_porst"},   bus.porst,   0);
    chk({tag, "_retries"}, bus.retries, 0);
    for (int i = 0; i < NCH; i++) chk({tag, "_trim_hold"}, trim_of(i), trim_m[i]);
  endtask

  task automatic wait_ready(input string tag, input int exp_edges);
    while (!bus.ready && edges < exp_edges + 64) tick();
    chk({tag, "_ready"}, bus.ready, 1);
    chk({tag, "_lat"},   edges,     exp_edges);
  endtask

  // Ramp result: each enabled channel walked one LSB at a time to its target.
  task automatic check_ramp(input string tag);
    for (int i = 0; i < NCH; i++) begin
      int d;
      int sg;
      if (mask_m[i]) begin
        d  = tgt[i] - trim_m[i];
        sg = (d < 0) ? -1 : 1;
        if (d < 0) d = -d;
        chk({tag, "_nsteps"}, chg[i].size(), d);
        for (int j = 0; j < d && j < chg[i].size(); j++)
          chk({tag, "_step"}, chg[i][j], trim_m[i] + sg * (j + 1));
        chk({tag, "_trim"}, trim_of(i), tgt[i]);
        trim_m[i] = tgt[i];
      end else begin
        chk({tag, "_frozen_n"}, chg[i].size(), 0);
        chk({tag, "_frozen"},   trim_of(i),    trim_m[i]);
      end
    end
  endtask

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : stim
    int             exp_e;
    int             w;
    int             nsteps;
    int             raise_at;
    int             lost;
    logic [NCH-1:0] m;
    logic [NCH-1:0] okr;

    bus.en          = 1'b0;
    bus.ch_en       = '0;
    bus.trim_target = '0;
    bus.ok_async    = '1;
    mask_m          = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt[i]    = 0;
      trim_m[i] = 0;
    end
    clear_stats();

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_porst",   bus.porst,   0);
    chk("rst_trim",    bus.trim,    0);
    chk("rst_ready",   bus.ready,   0);
    chk("rst_fail",    bus.fail,    0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_retries", bus.retries, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Empty channel mask keeps the block idle
    bus.en = 1'b1;
    repeat (3) tick();
    chk("zero_mask_busy",  bus.busy,  0);
    chk("zero_mask_porst", bus.porst, 0);
    bus.en = 1'b0;
    tick();

    // Nominal: targets 5 and 3, both channels good
    tgt[0] = 5;
    tgt[1] = 3;
    start_run(2'b11, 2'b11);
    exp_e = ready_lat(max_dist(), 0);
    tick();
    chk("nom_porst", bus.porst, 2'b11);
    chk("nom_busy",  bus.busy,  1);
    wait_ready("nom", exp_e);
    chk("nom_porst_len", porst_cyc,   P);
    chk("nom_kicks",     kick_n,      1);
    chk("nom_retries",   bus.retries, 0);
    chk("nom_busy_done", bus.busy,    0);
    check_ramp("nom");

    // Retrim in DONE: ch0 5 -> 2
    tgt[0] = 2;
    drive_tgt();
    clear_stats();
    exp_e = 2 + R * max_dist();
    tick();
    chk("retrim_ready_low", bus.ready, 0);
    chk("retrim_busy",      bus.busy,  1);
    wait_ready("retrim", exp_e);
    check_ramp("retrim");

    // Abort mid-RAMP toward the top code
    tgt[0] = TMAX;
    drive_tgt();
    clear_stats();
    w = int'($urandom_range(2, 10 * R));
    repeat (w - 1) tick();
    bus.en = 1'b0;
    tick();
    nsteps = (w - 2) / R;
    if (nsteps > TMAX - trim_m[0]) nsteps = TMAX - trim_m[0];
    chk("abort_busy",  bus.busy,  0);
    chk("abort_ready", bus.ready, 0);
    chk("abort_porst", bus.porst, 0);
    chk("abort_trim0", trim_of(0), trim_m[0] + nsteps);
    chk("abort_trim1", trim_of(1), trim_m[1]);
    trim_m[0] = trim_m[0] + nsteps;
    repeat (R + 1) tick();
    chk("abort_hold", trim_of(0), trim_m[0]);

    // Code-space boundaries: top and bottom codes, no wrap afterwards
    tgt[0] = TMAX;
    tgt[1] = 0;
    start_run(2'b11, 2'b11);
    wait_ready("bound", ready_lat(max_dist(), 0));
    check_ramp("bound");
    repeat (3 * R) tick();
    chk("bound_top", trim_of(0), TMAX);
    chk("bound_bot", trim_of(1), 0);
    chk("bound_rdy", bus.ready,  1);

    // Supervision: short dropout is ignored
    clear_stats();
    lost = 0;
    bus.ok_async[0] = 1'b0;
    repeat (DROP - 1) begin
      tick();
      if (!bus.ready) lost++;
    end
    bus.ok_async = '1;
    repeat (DROP + 3) begin
      tick();
      if (!bus.ready) lost++;
    end
    chk("sup_short_lost", lost,   0);
    chk("sup_short_kick", kick_n, 0);

    // Supervision: full dropout with a simultaneous target change re-kicks
    clear_stats();
    bus.ok_async[0] = 1'b0;
    repeat (DROP) tick();
    bus.ok_async = '1;
    tick();
    chk("sup_pre_ready", bus.ready, 1);
    tgt[1] = int'($urandom_range(1, TMAX));
    drive_tgt();
    tick();
    chk("sup_kick_porst", bus.porst,   2'b11);
    chk("sup_ready_low",  bus.ready,   0);
    chk("sup_retries",    bus.retries, 0);
    chk("sup_busy",       bus.busy,    1);
    for (int i = 0; i < NCH; i++) chk("sup_trim_held", trim_of(i), trim_m[i]);
    wait_ready("sup", DROP + 1 + ready_lat(max_dist(), 0));
    chk("sup_kicks", kick_n, 1);
    check_ramp("sup");

    // Retry then fail
    stop("rf_pre");
    start_run(2'b11, 2'b00);
    exp_e = 1 + (MAX_RETRY + 1) * (P + S + 1);
    while (!bus.fail && edges < exp_e + 64) tick();
    chk("rf_fail",      bus.fail,    1);
    chk("rf_lat",       edges,       exp_e);
    chk("rf_busy",      bus.busy,    0);
    chk("rf_retries",   bus.retries, MAX_RETRY);
    chk("rf_kicks",     kick_n,      MAX_RETRY + 1);
    chk("rf_porst_len", porst_cyc,   (MAX_RETRY + 1) * P);
    for (int j = 0; j <= int'(MAX_RETRY); j++)
      chk("rf_kick_retry", (j < kick_ret.size()) ? kick_ret[j] : -1, j);
    repeat (5) tick();
    chk("rf_fail_hold", bus.fail, 1);
    stop("rf_off");

    // Late good: ok rises during the second SETTLE
    tgt[0] = int'($urandom_range(0, TMAX));
    tgt[1] = int'($urandom_range(0, TMAX));
    start_run(2'b11, 2'b00);
    exp_e    = ready_lat(max_dist(), 1);
    raise_at = int'($urandom_range(2 * P + S + 3, 2 * P + 2 * S - 1));
    while (edges < raise_at - 1) tick();
    bus.ok_async = '1;
    wait_ready("late", exp_e);
    chk("late_retries", bus.retries, 1);
    chk("late_kicks",   kick_n,      2);
    check_ramp("late");

    // Random masks and targets; ch_en changes after capture are ignored
    for (int k = 0; k < 3; k++) begin
      stop("rnd_pre");
      m   = NCH'($urandom_range(1, (1 << NCH) - 1));
      okr = m | NCH'($urandom());
      for (int i = 0; i < NCH; i++) tgt[i] = int'($urandom_range(0, TMAX));
      start_run(m, okr);
      exp_e = ready_lat(max_dist(), 0);
      tick();
      chk("rnd_porst", bus.porst, m);
      bus.ch_en = NCH'($urandom());
      tick();
      chk("rnd_porst_kept", bus.porst, m);
      wait_ready("rnd", exp_e);
      chk("rnd_retries", bus.retries, 0);
      check_ramp("rnd");
    end

    // Asynchronous reset mid-sequence
    stop("ar_pre");
    tgt[0] = int'($urandom_range(0, TMAX));
    tgt[1] = int'($urandom_range(0, TMAX));
    start_run(2'b11, 2'b11);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_porst",   bus.porst,   0);
    chk("ar_busy",    bus.busy,    0);
    chk("ar_trim",    bus.trim,    0);
    chk("ar_retries", bus.retries, 0);
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) trim_m[i] = 0;
    repeat (2) tick();

    // Channel mask 01 with ch1 comparator low
    tgt[0] = int'($urandom_range(1, TMAX));
    tgt[1] = int'($urandom_range(1, TMAX));
    start_run(2'b01, 2'b01);
    exp_e = ready_lat(max_dist(), 0);
    tick();
    chk("mask_porst", bus.porst, 2'b01);
    bus.ch_en = 2'b11;
    tick();
    chk("mask_porst_kept", bus.porst, 2'b01);
    wait_ready("mask", exp_e);
    chk("mask_retries", bus.retries, 0);
    check_ramp("mask");
    chk("mask_ch1_zero", trim_of(1), 0);
    lost = 0;
    repeat (2 * DROP + 2) begin
      tick();
      if (!bus.ready) lost++;
    end
    chk("mask_ch1_ok_ignored", lost, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
